// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry in-order retirement buffer.
//   Allocation : alloc_valid/alloc_dest_valid/alloc_dest_reg in; alloc_ready and
//                alloc_tag (= tail pointer) out.
//   Writeback  : two ports wb_valid/wb_tag/wb_data. If both ports name the
//                same tag, port 1 wins.
//   Retirement : up to 3 lanes, registered. The lanes are
//                retirement_write_data_enable, retirement_target_reg,
//                retirement_write_data and retire_tag.
//   Status     : rob_count, the number of occupied entries (0-16).
//   Option     : ROB_FLUSH_EN adds the flush input, which empties the buffer
//                synchronously.
module reorder_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc_valid,
  input  logic        alloc_dest_valid,
  input  logic [3:0]  alloc_dest_reg,
  output logic        alloc_ready,
  output logic [3:0]  alloc_tag,
  input  logic        wb_valid [0:1],
  input  logic [3:0]  wb_tag   [0:1],
  input  logic [15:0] wb_data  [0:1],
  output logic        retirement_write_data_enable [0:2],
  output logic [3:0]  retirement_target_reg        [0:2],
  output logic [15:0] retirement_write_data        [0:2],
  output logic [3:0]  retire_tag                   [0:2],
  output logic [4:0]  rob_count
`ifdef ROB_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned RETIRE_W = 3;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned N_W      = 2;

  // Entry state. Control bits are reset; payload bits are not.
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, dv_q, dv_d;
  logic [REG_W-1:0]  dreg_q  [DEPTH];
  logic [REG_W-1:0]  dreg_d  [DEPTH];
  logic [DATA_W-1:0] edata_q [DEPTH];
  logic [DATA_W-1:0] edata_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered retirement lanes.
  logic [RETIRE_W-1:0] ret_en_q, ret_en_d;
  logic [REG_W-1:0]    ret_reg_q  [RETIRE_W];
  logic [REG_W-1:0]    ret_reg_d  [RETIRE_W];
  logic [DATA_W-1:0]   ret_data_q [RETIRE_W];
  logic [DATA_W-1:0]   ret_data_d [RETIRE_W];
  logic [TAG_W-1:0]    ret_tag_q  [RETIRE_W];
  logic [TAG_W-1:0]    ret_tag_d  [RETIRE_W];

  logic [TAG_W-1:0]    lane_idx [RETIRE_W];
  logic [RETIRE_W-1:0] lane_ok, lane_go;
  logic [N_W-1:0]      n_c;
  logic                run_c, accept_c, flush_c;

`ifdef ROB_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Ready is based on the current count only. Retirements in the same cycle
  // cannot free an entry early.
  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign alloc_tag   = tail_q;
  assign rob_count   = count_q;
  assign accept_c    = alloc_valid & alloc_ready;

  // Lane i examines entry head+i. The 4-bit add wraps naturally.
  for (genvar i = 0; i < RETIRE_W; i++) begin : g_lane
    assign lane_idx[i] = head_q + TAG_W'(i);
    assign lane_ok[i]  = valid_q[lane_idx[i]] & done_q[lane_idx[i]];
    assign lane_go[i]  = (N_W'(i) < n_c);
    assign retirement_write_data_enable[i] = ret_en_q[i];
    assign retirement_target_reg[i]        = ret_reg_q[i];
    assign retirement_write_data[i]        = ret_data_q[i];
    assign retire_tag[i]                   = ret_tag_q[i];
  end

  // Count the consecutive completed entries starting at head.
  always_comb begin
    n_c   = '0;
    run_c = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      run_c = run_c & lane_ok[i];
      if (run_c) n_c = n_c + N_W'(1);
    end
  end

  // Next state. Writeback is applied first, then retire clears, then
  // allocation. Flush overrides all of these.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    dv_d    = dv_q;
    dreg_d  = dreg_q;
    edata_d = edata_q;
    head_d  = head_q + TAG_W'(n_c);
    tail_d  = tail_q;
    count_d = count_q - CNT_W'(n_c);
    ret_en_d = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      ret_reg_d[i]  = '0;
      ret_data_d[i] = '0;
      ret_tag_d[i]  = '0;
    end

    // Writebacks to unallocated tags are ignored. Port 1 overwrites port 0.
    for (int k = 0; k < 2; k++) begin
      if (wb_valid[k] && valid_q[wb_tag[k]]) begin
        done_d[wb_tag[k]]  = 1'b1;
        edata_d[wb_tag[k]] = wb_data[k];
      end
    end

    for (int i = 0; i < RETIRE_W; i++) begin
      if (lane_go[i]) begin
        valid_d[lane_idx[i]] = 1'b0;
        done_d[lane_idx[i]]  = 1'b0;
        ret_en_d[i]   = dv_q[lane_idx[i]];
        ret_reg_d[i]  = dreg_q[lane_idx[i]];
        ret_data_d[i] = edata_q[lane_idx[i]];
        ret_tag_d[i]  = lane_idx[i];
      end
    end

    if (accept_c) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      dv_d[tail_q]    = alloc_dest_valid;
      dreg_d[tail_q]  = alloc_dest_reg;
      tail_d          = tail_q + TAG_W'(1);
      count_d         = count_d + CNT_W'(1);
    end

    if (flush_c) begin
      valid_d  = '0;
      done_d   = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      ret_en_d = '0;
      for (int i = 0; i < RETIRE_W; i++) begin
        ret_reg_d[i]  = '0;
        ret_data_d[i] = '0;
        ret_tag_d[i]  = '0;
      end
    end
  end

  // Control and retirement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ret_en_q <= '0;
      for (int i = 0; i < RETIRE_W; i++) begin
        ret_reg_q[i]  <= '0;
        ret_data_q[i] <= '0;
        ret_tag_q[i]  <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ret_en_q   <= ret_en_d;
      ret_reg_q  <= ret_reg_d;
      ret_data_q <= ret_data_d;
      ret_tag_q  <= ret_tag_d;
    end
  end

  // Payload is qualified by valid/done, so it needs no reset.
  always_ff @(posedge clk) begin
    dv_q    <= dv_d;
    dreg_q  <= dreg_d;
    edata_q <= edata_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer. A queue-based program-order model is checked
// against the DUT every cycle, and literal checks pin down the directed cases.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        av_i, adv_i, fl_i;
  logic [3:0]  adr_i;
  logic        wv_i [0:1];
  logic [3:0]  wt_i [0:1];
  logic [15:0] wd_i [0:1];
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        ren  [0:2];
  logic [3:0]  rreg [0:2];
  logic [15:0] rdat [0:2];
  logic [3:0]  rtag [0:2];
  logic [4:0]  rob_count;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(av_i), .alloc_dest_valid(adv_i), .alloc_dest_reg(adr_i),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wv_i), .wb_tag(wt_i), .wb_data(wd_i),
    .retirement_write_data_enable(ren), .retirement_target_reg(rreg),
    .retirement_write_data(rdat), .retire_tag(rtag),
    .rob_count(rob_count)
`ifdef ROB_FLUSH_EN
    , .flush(fl_i)
`endif
  );

  typedef struct {
    logic [3:0]  tag;
    bit          dv;
    logic [3:0]  dr;
    bit          done;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_tail;
  bit          e_act [3];
  bit          e_en  [3];
  logic [3:0]  e_tag [3];
  logic [3:0]  e_reg [3];
  logic [15:0] e_dat [3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    m_tail = '0;
    for (int i = 0; i < 3; i++) begin
      e_act[i] = 0; e_en[i] = 0; e_tag[i] = '0; e_reg[i] = '0; e_dat[i] = '0;
    end
  endfunction

  // Advance the model across one clock edge, using the inputs currently driven.
  function automatic void model_step();
    int n = 0;
    bit acc;
    acc = av_i && (mq.size() < 16);
    while (n < 3 && n < mq.size() && mq[n].done) n++;
    for (int i = 0; i < 3; i++) begin
      e_act[i] = (i < n);
      e_en[i]  = (i < n) && mq[i].dv;
      if (i < n) begin
        e_tag[i] = mq[i].tag; e_reg[i] = mq[i].dr; e_dat[i] = mq[i].data;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (wv_i[k]) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (mq[j].tag == wt_i[k]) begin
            ent_t e = mq[j];
            e.done = 1; e.data = wd_i[k];
            mq[j] = e;
          end
        end
      end
    end
    repeat (n) void'(mq.pop_front());
    if (acc) begin
      ent_t e;
      e.tag = m_tail; e.dv = adv_i; e.dr = adr_i; e.done = 0; e.data = '0;
      mq.push_back(e);
      m_tail = m_tail + 4'd1;
    end
`ifdef ROB_FLUSH_EN
    if (fl_i) begin
      mq.delete();
      m_tail = '0;
      for (int i = 0; i < 3; i++) begin e_act[i] = 0; e_en[i] = 0; end
    end
`endif
  endfunction

  task automatic check_model();
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() != 16));
    chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    chk("rob_count", 32'(rob_count), 32'(mq.size()));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lane%0d_en", i), 32'(ren[i]), 32'(e_en[i]));
      if (e_act[i]) chk($sformatf("lane%0d_tag", i), 32'(rtag[i]), 32'(e_tag[i]));
      if (e_en[i]) begin
        chk($sformatf("lane%0d_reg", i), 32'(rreg[i]), 32'(e_reg[i]));
        chk($sformatf("lane%0d_data", i), 32'(rdat[i]), 32'(e_dat[i]));
      end
    end
  endtask

  // Drive one cycle at the negedge, step the model, then compare at the next negedge.
  task automatic cyc(input bit av, input bit adv, input logic [3:0] adr,
                     input bit w0, input logic [3:0] t0, input logic [15:0] d0,
                     input bit w1, input logic [3:0] t1, input logic [15:0] d1,
                     input bit fl);
    av_i = av; adv_i = adv; adr_i = adr;
    wv_i[0] = w0; wt_i[0] = t0; wd_i[0] = d0;
    wv_i[1] = w1; wt_i[1] = t1; wd_i[1] = d1;
    fl_i = fl;
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    cyc(0, 0, 4'd0, 0, 4'd0, 16'd0, 0, 4'd0, 16'd0, 0);
  endtask

  task automatic do_reset();
    av_i = 0; adv_i = 0; adr_i = '0; fl_i = 0;
    for (int k = 0; k < 2; k++) begin wv_i[k] = 0; wt_i[k] = '0; wd_i[k] = '0; end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(rob_count), 32'd0);
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_tag", 32'(alloc_tag), 32'd0);
    for (int i = 0; i < 3; i++) chk("rst_en", 32'(ren[i]), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_clear();
    av_i = 0; adv_i = 0; adr_i = '0; fl_i = 0;
    for (int k = 0; k < 2; k++) begin wv_i[k] = 0; wt_i[k] = '0; wd_i[k] = '0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("init_tag", 32'(rtag[i]), 32'd0);
      chk("init_reg", 32'(rreg[i]), 32'd0);
      chk("init_data", 32'(rdat[i]), 32'd0);
    end
    do_reset();

    // Out-of-order completion, then one in-order retirement of three lanes.
    cyc(1, 1, 4'd3, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'd4, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'd5, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd2, 16'h00CC, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd1, 16'h00BB, 0, 0, 0, 0);
    chk("ooo_wait", 32'(ren[0]), 32'd0);
    cyc(0, 0, 0, 1, 4'd0, 16'h00AA, 0, 0, 0, 0);
    chk("ooo_lat", 32'(ren[0]), 32'd0);
    idle();
    chk("ooo_en0", 32'(ren[0]), 32'd1);
    chk("ooo_en2", 32'(ren[2]), 32'd1);
    chk("ooo_r0", 32'({rreg[0], rdat[0]}), 32'h3_00AA);
    chk("ooo_r1", 32'({rreg[1], rdat[1]}), 32'h4_00BB);
    chk("ooo_r2", 32'({rreg[2], rdat[2]}), 32'h5_00CC);
    chk("ooo_cnt", 32'(rob_count), 32'd0);
    idle();
    chk("ooo_once", 32'(ren[0]), 32'd0);
    do_reset();

    // Entry without a destination, and both writeback ports hitting one tag.
    cyc(1, 0, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'd7, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd1, 16'h1111, 1, 4'd1, 16'h2222, 0);
    cyc(0, 0, 0, 1, 4'd0, 16'h5555, 0, 0, 0, 0);
    idle();
    chk("nd_en0", 32'(ren[0]), 32'd0);
    chk("nd_tag0", 32'(rtag[0]), 32'd0);
    chk("nd_en1", 32'(ren[1]), 32'd1);
    chk("nd_r1", 32'({rtag[1], rreg[1], rdat[1]}), 32'h17_2222);
    do_reset();

    // Fill to 16, then retire up to head 14 and exercise the cap and the wrap.
    for (int t = 0; t < 16; t++) cyc(1, 1, 4'(t + 1), 0, 0, 0, 0, 0, 0, 0);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_cnt", 32'(rob_count), 32'd16);
    chk("full_tag", 32'(alloc_tag), 32'd0);
    cyc(1, 1, 4'd9, 0, 0, 0, 0, 0, 0, 0);
    chk("full_17th", 32'(rob_count), 32'd16);
    for (int t = 0; t < 14; t += 2)
      cyc(0, 0, 0, 1, 4'(t), 16'(t), 1, 4'(t + 1), 16'(t + 1), 0);
    repeat (6) idle();
    chk("wrap_cnt2", 32'(rob_count), 32'd2);
    cyc(1, 1, 4'd9, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'd10, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd0, 16'h0A00, 1, 4'd1, 16'h0A01, 0);
    cyc(0, 0, 0, 1, 4'd14, 16'h0E0E, 1, 4'd15, 16'h0F0F, 0);
    idle();
    chk("wrap_l0", 32'({ren[0], rtag[0], rreg[0], rdat[0]}), 32'h1_EF_0E0E);
    chk("wrap_l1", 32'({ren[1], rtag[1], rreg[1], rdat[1]}), 32'h1_F0_0F0F);
    chk("wrap_l2", 32'({ren[2], rtag[2], rreg[2], rdat[2]}), 32'h1_09_0A00);
    idle();
    chk("wrap_l0b", 32'({ren[0], rtag[0], rreg[0], rdat[0]}), 32'h1_1A_0A01);
    chk("wrap_l1b", 32'(ren[1]), 32'd0);
    chk("wrap_head", 32'({rob_count, alloc_tag}), 32'h002);
    do_reset();

`ifdef ROB_FLUSH_EN
    for (int t = 0; t < 5; t++) cyc(1, 1, 4'(t), 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4'd3, 16'h3333, 1, 4'd4, 16'h4444, 0);
    cyc(1, 1, 4'd6, 1, 4'd0, 16'h0, 0, 0, 0, 1);
    chk("fl_cnt", 32'(rob_count), 32'd0);
    chk("fl_tag", 32'(alloc_tag), 32'd0);
    chk("fl_en", 32'(ren[0]), 32'd0);
    idle();
    do_reset();
`endif

    // Randomized traffic, with phases of alloc/writeback pressure and a mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      int ap, wp;
      bit w [2];
      logic [3:0] t [2];
      ap = ((c / 250) % 3 == 0) ? 90 : ((c / 250) % 3 == 1) ? 50 : 20;
      wp = ((c / 170) % 3 == 0) ? 15 : ((c / 170) % 3 == 1) ? 60 : 95;
      if (c == 1500) do_reset();
      for (int k = 0; k < 2; k++) begin
        w[k] = ($urandom_range(0, 99) < wp);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          t[k] = mq[$urandom_range(0, mq.size() - 1)].tag;
        else
          t[k] = 4'($urandom_range(0, 15));
      end
      cyc($urandom_range(0, 99) < ap, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
          w[0], t[0], 16'($urandom), w[1], t[1], 16'($urandom),
          ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
